// File: rtl/serial_rx_8_if.sv
// rtl/serial_rx_8_if.sv - parallel word output handshake of the serial receiver
interface serial_rx_8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Data_Out;
  logic             Out_Valid;
  logic             Out_Ready;

  modport master (output Data_Out, output Out_Valid, input Out_Ready);
  modport slave  (input Data_Out, input Out_Valid, output Out_Ready);
endinterface

// File: rtl/serial_rx_8.sv
// rtl/serial_rx_8.sv - serial-to-parallel receiver with one-entry output buffer
module serial_rx_8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Bit_In,
  input  logic                     Bit_Valid,
  input  logic                     Clr_Overrun,
  output logic                     Busy,
  output logic [$clog2(WIDTH)-1:0] Bit_Count,
  output logic                     Overrun,
  serial_rx_8_if.master            out_bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shifted;
  logic             take_bit, complete, load;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_shifted = {sr[WIDTH-2:0], Bit_In};
    end else begin : g_lsb
      assign sr_shifted = {Bit_In, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Start always wins over a bit arriving in the same cycle, including a completing one.
  always_comb begin
    state_nxt = state;
    take_bit  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!Start && Bit_Valid) begin
          take_bit = 1'b1;
          if (Bit_Count == LAST) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A finished word may replace the buffered one only if that one drains this same edge.
  assign load = complete && (!out_bus.Out_Valid || out_bus.Out_Ready);
  assign Busy = (state == SHIFT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr                <= '0;
      Bit_Count         <= '0;
      out_bus.Data_Out  <= '0;
      out_bus.Out_Valid <= 1'b0;
      Overrun           <= 1'b0;
    end else begin
      if (Start) begin
        sr        <= '0;
        Bit_Count <= '0;
      end else if (take_bit) begin
        sr        <= sr_shifted;
        Bit_Count <= complete ? '0 : Bit_Count + 1'b1;
      end

      if (load) begin
        out_bus.Data_Out  <= sr_shifted;
        out_bus.Out_Valid <= 1'b1;
      end else if (out_bus.Out_Valid && out_bus.Out_Ready) begin
        out_bus.Out_Valid <= 1'b0;
      end

      if (complete && !load) Overrun <= 1'b1;
      else if (Clr_Overrun)  Overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_rx_8.sv
// tb/tb_serial_rx_8.sv - bench for serial_rx_8, LSB-first and MSB-first builds side by side
module tb_serial_rx_8;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset, Start, Bit_In, Bit_Valid, Clr_Overrun, out_ready;
  logic Busy_l, Busy_m, Overrun_l, Overrun_m;
  logic [2:0] Cnt_l, Cnt_m;

  serial_rx_8_if #(.WIDTH(W)) bus_l ();
  serial_rx_8_if #(.WIDTH(W)) bus_m ();
  assign bus_l.Out_Ready = out_ready;
  assign bus_m.Out_Ready = out_ready;

  serial_rx_8 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Clr_Overrun(Clr_Overrun), .Busy(Busy_l), .Bit_Count(Cnt_l), .Overrun(Overrun_l),
    .out_bus(bus_l));

  serial_rx_8 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Clr_Overrun(Clr_Overrun), .Busy(Busy_m), .Bit_Count(Cnt_m), .Overrun(Overrun_m),
    .out_bus(bus_m));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame bits collected in arrival order, words built when WIDTH bits are in.
  bit         m_busy, m_valid, m_over;
  bit [W-1:0] m_data_l, m_data_m;
  bit         m_bits[$];

  function automatic void model_step(bit rst, bit st, bit bv, bit bi, bit rdy, bit clr);
    bit         done, drain;
    bit [W-1:0] wl, wm;
    done  = 1'b0;
    drain = m_valid && rdy;
    wl    = '0;
    wm    = '0;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_over = 0; m_data_l = '0; m_data_m = '0;
      m_bits.delete();
      return;
    end
    if (st) begin
      m_bits.delete();
      m_busy = 1'b1;
    end else if (m_busy && bv) begin
      m_bits.push_back(bi);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = m_bits[i];
          wm[W-1-i]   = m_bits[i];
        end
        done   = 1'b1;
        m_busy = 1'b0;
        m_bits.delete();
      end
    end
    if (done && (!m_valid || drain)) begin
      m_valid = 1'b1; m_data_l = wl; m_data_m = wm;
      if (clr) m_over = 1'b0;
    end else if (done) begin
      m_over = 1'b1;
    end else begin
      if (drain) m_valid = 1'b0;
      if (clr)   m_over  = 1'b0;
    end
  endfunction

  task automatic cyc(input bit rst, input bit st, input bit bv, input bit bi, input bit rdy, input bit clr);
    Reset = rst; Start = st; Bit_Valid = bv; Bit_In = bi; out_ready = rdy; Clr_Overrun = clr;
    @(posedge Clk);
    model_step(rst, st, bv, bi, rdy, clr);
    #1;
  endtask

  // Sends word[0] first; rdy_last drives Out_Ready on the completing cycle.
  task automatic send_frame(input logic [7:0] word, input bit rdy_last);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) cyc(0, 0, 1, word[i], (i == W - 1) ? rdy_last : 1'b0, 0);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 0);
    checks++;
    if (Busy_l !== 1'b0 || Cnt_l !== 3'd0 || bus_l.Out_Valid !== 1'b0 || bus_l.Data_Out !== 8'h00 || Overrun_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_l: busy=%b cnt=%0d valid=%b data=%h ovr=%b, want all 0", Busy_l, Cnt_l, bus_l.Out_Valid, bus_l.Data_Out, Overrun_l);
    end
    checks++;
    if (Busy_m !== 1'b0 || Cnt_m !== 3'd0 || bus_m.Out_Valid !== 1'b0 || bus_m.Data_Out !== 8'h00 || Overrun_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_m: busy=%b cnt=%0d valid=%b data=%h ovr=%b, want all 0", Busy_m, Cnt_m, bus_m.Out_Valid, bus_m.Data_Out, Overrun_m);
    end
  endtask

  task automatic test_basic_frame;
    send_frame(8'hA5, 0);
    checks++;
    if (bus_l.Data_Out !== 8'hA5 || bus_l.Out_Valid !== 1'b1 || Busy_l !== 1'b0 || Cnt_l !== 3'd0) begin
      errors++;
      $display("FAIL basic_l: data=%h valid=%b busy=%b cnt=%0d, want a5 1 0 0", bus_l.Data_Out, bus_l.Out_Valid, Busy_l, Cnt_l);
    end
    checks++;
    if (bus_m.Data_Out !== 8'hA5 || bus_m.Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_m: data=%h valid=%b, want a5 1", bus_m.Data_Out, bus_m.Out_Valid);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (bus_l.Out_Valid !== 1'b0 || bus_m.Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: valid_l=%b valid_m=%b, want 0 0", bus_l.Out_Valid, bus_m.Out_Valid);
    end
  endtask

  task automatic test_bit_order;
    send_frame(8'h03, 0);
    checks++;
    if (bus_l.Data_Out !== 8'h03 || bus_m.Data_Out !== 8'hC0) begin
      errors++;
      $display("FAIL bit_order: data_l=%h data_m=%h, want 03 c0", bus_l.Data_Out, bus_m.Data_Out);
    end
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_stall;
    logic [7:0] w;
    w = 8'h3C;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, (i % 2) == 0, w[i/2], 0, 0);
      if ((i % 2) == 1 && i < 15) begin
        checks++;
        if (Cnt_l !== 3'((i + 1) / 2) || Busy_l !== 1'b1) begin
          errors++;
          $display("FAIL stall_cnt%0d: cnt=%0d busy=%b, want %0d 1", i, Cnt_l, Busy_l, (i + 1) / 2);
        end
      end
    end
    checks++;
    if (bus_l.Data_Out !== 8'h3C || bus_m.Data_Out !== 8'h3C || bus_l.Out_Valid !== 1'b1 || Busy_l !== 1'b0) begin
      errors++;
      $display("FAIL stall_word: data_l=%h data_m=%h valid=%b busy=%b, want 3c 3c 1 0", bus_l.Data_Out, bus_m.Data_Out, bus_l.Out_Valid, Busy_l);
    end
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overrun;
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    checks++;
    if (Overrun_l !== 1'b1 || bus_l.Data_Out !== 8'h11 || bus_m.Data_Out !== 8'h88 || bus_l.Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: ovr=%b data_l=%h data_m=%h valid=%b, want 1 11 88 1", Overrun_l, bus_l.Data_Out, bus_m.Data_Out, bus_l.Out_Valid);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (Overrun_l !== 1'b0 || Overrun_m !== 1'b0 || bus_l.Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clr: ovr_l=%b ovr_m=%b valid=%b, want 0 0 1", Overrun_l, Overrun_m, bus_l.Out_Valid);
    end
    send_frame(8'h22, 1);
    checks++;
    if (bus_l.Data_Out !== 8'h22 || bus_m.Data_Out !== 8'h44 || bus_l.Out_Valid !== 1'b1 || Overrun_l !== 1'b0) begin
      errors++;
      $display("FAIL drain_load: data_l=%h data_m=%h valid=%b ovr=%b, want 22 44 1 0", bus_l.Data_Out, bus_m.Data_Out, bus_l.Out_Valid, Overrun_l);
    end
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_abort_and_reset;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1'($urandom), 0, 0);
    send_frame(8'hF0, 0);
    checks++;
    if (bus_l.Data_Out !== 8'hF0 || bus_m.Data_Out !== 8'h0F || Overrun_l !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: data_l=%h data_m=%h ovr=%b, want f0 0f 0", bus_l.Data_Out, bus_m.Data_Out, Overrun_l);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    checks++;
    if (bus_l.Out_Valid !== 1'b0 || Busy_l !== 1'b1 || Cnt_l !== 3'd0) begin
      errors++;
      $display("FAIL start_wins: valid=%b busy=%b cnt=%0d, want 0 1 0", bus_l.Out_Valid, Busy_l, Cnt_l);
    end
    send_frame(8'h5A, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    checks++;
    if (Busy_l !== 1'b0 || Cnt_l !== 3'd0 || bus_l.Out_Valid !== 1'b0 || bus_l.Data_Out !== 8'h00 || bus_m.Data_Out !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: busy=%b cnt=%0d valid=%b data_l=%h data_m=%h, want 0 0 0 00 00", Busy_l, Cnt_l, bus_l.Out_Valid, bus_l.Data_Out, bus_m.Data_Out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    words = '{8'h96, 8'h4E, 8'hD1};
    for (int f = 0; f < 3; f++) begin
      send_frame(words[f], f != 0);
      checks++;
      if (bus_l.Data_Out !== words[f] || bus_m.Data_Out !== {<<{words[f]}} || bus_l.Out_Valid !== 1'b1 || Overrun_l !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: data_l=%h data_m=%h valid=%b ovr=%b, want %h %h 1 0", f, bus_l.Data_Out, bus_m.Data_Out, bus_l.Out_Valid, Overrun_l, words[f], {<<{words[f]}});
      end
    end
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if (Busy_l !== m_busy || Busy_m !== m_busy || Cnt_l !== 3'(m_bits.size()) || Cnt_m !== 3'(m_bits.size()) ||
          bus_l.Out_Valid !== m_valid || bus_m.Out_Valid !== m_valid || Overrun_l !== m_over || Overrun_m !== m_over ||
          (m_valid && (bus_l.Data_Out !== m_data_l || bus_m.Data_Out !== m_data_m))) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: busy=%b cnt=%0d valid=%b ovr=%b dl=%h dm=%h, want %b %0d %b %b %h %h",
                   n, Busy_l, Cnt_l, bus_l.Out_Valid, Overrun_l, bus_l.Data_Out, bus_m.Data_Out,
                   m_busy, m_bits.size(), m_valid, m_over, m_data_l, m_data_m);
      end
    end
  endtask

  initial begin
    Reset = 1; Start = 0; Bit_In = 0; Bit_Valid = 0; Clr_Overrun = 0; out_ready = 0;
    test_reset();
    test_basic_frame();
    test_bit_order();
    test_stall();
    test_overrun();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
